// File: rtl/jb_dbgbuf_capture_ctrl.sv
// jb_dbgbuf_capture_ctrl
// Capture/readback sequencer for the 64-bit URAM debug buffer.
// Port A streams debug samples into a circular buffer with a pre-trigger
// window and a post-trigger count; port B turns trigger-relative host reads
// into physical reads and returns data after a fixed latency.
// Optional feature macro: DBGBUF_TIMESTAMP_EN (trigger timestamp capture).
module jb_dbgbuf_capture_ctrl #(
  parameter int AWIDTH = 18,
  parameter int RD_LAT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [AWIDTH-1:0] pre_len,
  input  logic [AWIDTH-1:0] post_len,
  input  logic              cap_vld,
  input  logic [63:0]       cap_data,
  input  logic              trig,
  output logic [2:0]        state,
  output logic              done,
  output logic [AWIDTH-1:0] trig_addr,
  output logic [31:0]       trig_ts,
  input  logic              rd_req,
  input  logic [AWIDTH-1:0] rd_off,
  output logic              rd_vld,
  output logic [63:0]       rd_data,
  output logic              ena,
  output logic [7:0]        wea,
  output logic [19:0]       addra,
  output logic [63:0]       dina,
  input  logic [63:0]       douta,
  output logic              enb,
  output logic [7:0]        web,
  output logic [19:0]       addrb,
  output logic [63:0]       dinb,
  input  logic [63:0]       doutb
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [AWIDTH:0] LP_DEPTH_M1 = {1'b0, {AWIDTH{1'b1}}};

  state_t            r_state;
  logic              r_done;
  logic [AWIDTH-1:0] r_wp;
  logic [AWIDTH-1:0] r_fill;
  logic [AWIDTH-1:0] r_pre_q;
  logic [AWIDTH-1:0] r_post_q;
  logic [AWIDTH-1:0] r_cnt;
  logic [AWIDTH-1:0] r_start;
  logic [AWIDTH-1:0] r_trig_addr;

  logic              r_ena;
  logic [7:0]        r_wea;
  logic [AWIDTH-1:0] r_addra;
  logic [63:0]       r_dina;

  logic              r_enb;
  logic [AWIDTH-1:0] r_addrb;
  logic [RD_LAT-1:0] r_vld_sr;

  logic [AWIDTH-1:0] w_pre_q;
  logic [AWIDTH:0]   w_post_room;
  logic [AWIDTH-1:0] w_post_q;
  logic [AWIDTH-1:0] w_fill_nxt;
  logic              w_capturing;
  logic              w_wr;
  logic              w_trig_hit;
  logic [63:0]       w_dina;
  logic              w_unused;

  // Clamp the window so pre + post + trigger sample never exceeds the buffer.
  assign w_pre_q     = ({1'b0, pre_len} > LP_DEPTH_M1) ? LP_DEPTH_M1[AWIDTH-1:0] : pre_len;
  assign w_post_room = LP_DEPTH_M1 - {1'b0, w_pre_q};
  assign w_post_q    = ({1'b0, post_len} > w_post_room) ? w_post_room[AWIDTH-1:0] : post_len;

  assign w_fill_nxt  = r_fill + 1'b1;
  assign w_capturing = (r_state == S_FILL) || (r_state == S_WAIT_TRIG) || (r_state == S_POST);
  // abort suppresses the write that would otherwise be issued next cycle.
  assign w_wr        = w_capturing && cap_vld && !abort;
  assign w_trig_hit  = w_wr && (r_state == S_WAIT_TRIG) && trig;

  // Capture sequencer: state, write pointer, window counters, trigger latch.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // every register here uses non-blocking assignment to avoid update races.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_wp        <= '0;
      r_fill      <= '0;
      r_pre_q     <= '0;
      r_post_q    <= '0;
      r_cnt       <= '0;
      r_start     <= '0;
      r_trig_addr <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            r_pre_q  <= w_pre_q;
            r_post_q <= w_post_q;
            r_wp     <= '0;
            r_fill   <= '0;
            r_done   <= 1'b0;
            r_state  <= (w_pre_q == '0) ? S_WAIT_TRIG : S_FILL;
          end
        end
        S_FILL: begin
          if (cap_vld) begin
            r_wp   <= r_wp + 1'b1;
            r_fill <= w_fill_nxt;
            if (w_fill_nxt == r_pre_q) r_state <= S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (cap_vld) begin
            r_wp <= r_wp + 1'b1;
            if (trig) begin
              r_trig_addr <= r_wp;
              r_start     <= r_wp - r_pre_q;
              if (r_post_q == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_POST;
                r_cnt   <= r_post_q;
              end
            end
          end
        end
        S_POST: begin
          if (cap_vld) begin
            r_wp  <= r_wp + 1'b1;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == AWIDTH'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DBGBUF_TIMESTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_trig_ts;

  // Free-running timestamp; latched on the trigger write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts      <= '0;
      r_trig_ts <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (w_trig_hit) r_trig_ts <= r_ts;
    end
  end

  assign trig_ts = r_trig_ts;
  assign w_dina  = w_trig_hit ? {r_ts, cap_data[31:0]} : cap_data;
`else
  assign trig_ts = '0;
  assign w_dina  = cap_data;
`endif

  // Port A: one registered write per accepted sample, at the current pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ena   <= 1'b0;
      r_wea   <= '0;
      r_addra <= '0;
      r_dina  <= '0;
    end else begin
      r_ena <= w_wr;
      r_wea <= w_wr ? 8'hFF : 8'h00;
      if (w_wr) begin
        r_addra <= r_wp;
        r_dina  <= w_dina;
      end
    end
  end

  // Port B: translate host offsets and track read latency with a valid tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_enb    <= 1'b0;
      r_addrb  <= '0;
      r_vld_sr <= '0;
    end else begin
      r_enb <= rd_req;
      if (rd_req) r_addrb <= (r_state == S_DONE) ? (r_start + rd_off) : rd_off;
      r_vld_sr <= (r_vld_sr << 1) | RD_LAT'(r_enb);
    end
  end

  assign state     = r_state;
  assign done      = r_done;
  assign trig_addr = r_trig_addr;

  assign ena   = r_ena;
  assign wea   = r_wea;
  assign addra = 20'(r_addra);
  assign dina  = r_dina;

  assign enb   = r_enb;
  assign web   = '0;
  assign addrb = 20'(r_addrb);
  assign dinb  = '0;

  assign rd_vld  = r_vld_sr[RD_LAT-1];
  assign rd_data = rd_vld ? doutb : '0;

  // Port A read data is not used by this block.
  assign w_unused = ^douta;

endmodule
